dqsw_delay_trainer: RTL and testbench
=====================================

Name: dqsw_delay_trainer

Overview:
- Per-lane DQSW training sequencer that directly drives the DQSW training IOD's delay-line controls and consumes its eye-monitor flags.
- Sweeps the delay line up one tap at a time and classifies each tap from the EARLY/LATE flags.
- Locks on the first EARLY-to-LATE transition, backs off a fixed number of taps, and reports the final tap position.
- One instance per DQ lane, controlled by the DDR4 PHY training controller.

Parameters:
MAX_TAPS, 128, delay-line taps swept (2..256); sweep ends at tap MAX_TAPS-1
SETTLE_CYCLES, 8, idle cycles after flag clear before sampling (>=1)
SAMPLE_CYCLES, 16, cycles over which EARLY/LATE are OR-accumulated (>=1)
BACKOFF_TAPS, 2, taps moved down after the transition is found (0..15)

Ports:
FAB_CLK  in  1  fabric clock; all logic on rising edge
RESET  in  1  asynchronous, active-high reset
TRAIN_START  in  1  one-cycle start pulse
TRAIN_DONE  out  1  training succeeded; held high
TRAIN_ERROR  out  1  training failed; held high
TAP_COUNT  out  8  current/final tap position, relative to load value
EYE_MONITOR_EARLY  in  1  from IOD
EYE_MONITOR_LATE  in  1  from IOD
DELAY_LINE_OUT_OF_RANGE  in  1  from IOD
EYE_MONITOR_CLEAR_FLAGS  out  1  to IOD; one-cycle pulse
DELAY_LINE_MOVE  out  1  to IOD; one-cycle pulse = one tap step
DELAY_LINE_DIRECTION  out  1  to IOD; 1 = increment, 0 = decrement; valid with MOVE
DELAY_LINE_LOAD  out  1  to IOD; one-cycle pulse that reloads the static delay

Behaviour:
- Reset: RESET=1 asynchronously forces state IDLE, all outputs 0, TAP_COUNT=0, internal counters/flags cleared. Reset mid-training aborts with no further pulses; the IOD delay is not restored.
- All outputs are registered.
- States: IDLE, LOAD, CLEAR, SETTLE, SAMPLE, EVAL, MOVE, BACKOFF, DONE, ERROR.
- IDLE/DONE/ERROR: TRAIN_START=1 -> LOAD next cycle; TRAIN_DONE/TRAIN_ERROR drop in that same transition.
- TRAIN_START in any other state is ignored.
- LOAD: 1 cycle, DELAY_LINE_LOAD=1; TAP_COUNT<=0; prev_class<=X -> CLEAR.
- CLEAR: 1 cycle, EYE_MONITOR_CLEAR_FLAGS=1; early_seen, late_seen <= 0 -> SETTLE.
- SETTLE: exactly SETTLE_CYCLES cycles -> SAMPLE.
- SAMPLE: exactly SAMPLE_CYCLES cycles; early_seen |= EARLY, late_seen |= LATE each cycle -> EVAL.
- EVAL: 1 cycle. Class = E if early_seen & !late_seen; L if late_seen & !early_seen; otherwise X. Then, in priority order:
  - prev_class==E and class==L -> BACKOFF, or DONE if BACKOFF_TAPS=0.
  - else TAP_COUNT==MAX_TAPS-1 -> ERROR.
  - else -> MOVE.
  - prev_class<=class in all cases.
- MOVE: 1 cycle, DELAY_LINE_MOVE=1, DIRECTION=1; TAP_COUNT+1 -> CLEAR.
- Per-tap cost: CLEAR 1 + SETTLE_CYCLES + SAMPLE_CYCLES + EVAL 1 + MOVE 1 cycles.
- BACKOFF:
  - Alternating pulse/gap cycles; pulse cycle has MOVE=1, DIRECTION=0, TAP_COUNT-1.
  - Issues min(BACKOFF_TAPS, TAP_COUNT at entry) pulses; TAP_COUNT never goes below 0.
  - -> DONE on the cycle after the last gap.
- DONE: TRAIN_DONE=1, TAP_COUNT frozen. ERROR: TRAIN_ERROR=1, TAP_COUNT frozen.
- DELAY_LINE_OUT_OF_RANGE=1 sampled in LOAD..BACKOFF -> ERROR next cycle. This has priority over every other transition, and no MOVE is issued in that cycle.
- DIRECTION holds its last value when MOVE=0; it reads 0 after reset.
- X or L at a tap not preceded by E keeps sweeping. A transition requires adjacent taps E then L.
- TRAIN_DONE and TRAIN_ERROR are never high together.

Test Plan:
- Reset during SAMPLE at tap 3 -> all outputs 0 within the same cycle; next TRAIN_START -> DELAY_LINE_LOAD pulse, TAP_COUNT=0.
- MAX_TAPS=32, SETTLE=4, SAMPLE=8, BACKOFF=2; model EARLY for taps 0-9, LATE from tap 10 -> LOAD, 10 up-MOVEs spaced 15 cycles apart, 2 down-MOVEs one cycle apart, TAP_COUNT=8, TRAIN_DONE=1, TRAIN_ERROR=0.
- Same parameters, EARLY at every tap -> 31 up-MOVEs, TRAIN_ERROR=1, TAP_COUNT=31, no down-MOVEs.
- OUT_OF_RANGE raised during SETTLE at tap 5 -> TRAIN_ERROR=1 next cycle, TAP_COUNT=5, no further MOVE or CLEAR pulses.
- EARLY at tap 0, LATE at tap 1, BACKOFF=2 -> exactly 1 down-MOVE (clamp), TAP_COUNT=0, TRAIN_DONE=1.
- Taps 0-3 both flags set (X), tap 4 LATE, tap 5 EARLY, tap 6 LATE -> no lock at 4; locks at 6 and finishes with TAP_COUNT=4. TRAIN_START pulsed mid-sweep is ignored.

Source files
------------

// File: rtl/dqsw_delay_trainer_if.sv
// Signal bundle between one DQSW delay trainer (master) and the training
// controller / IOD side (slave) of a single DQ lane.
interface dqsw_delay_trainer_if;
    logic       TRAIN_START;
    logic       TRAIN_DONE;
    logic       TRAIN_ERROR;
    logic [7:0] TAP_COUNT;
    logic       EYE_MONITOR_EARLY;
    logic       EYE_MONITOR_LATE;
    logic       DELAY_LINE_OUT_OF_RANGE;
    logic       EYE_MONITOR_CLEAR_FLAGS;
    logic       DELAY_LINE_MOVE;
    logic       DELAY_LINE_DIRECTION;
    logic       DELAY_LINE_LOAD;

    modport master (
        input  TRAIN_START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
        output TRAIN_DONE, TRAIN_ERROR, TAP_COUNT, EYE_MONITOR_CLEAR_FLAGS,
               DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD
    );

    modport slave (
        output TRAIN_START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
        input  TRAIN_DONE, TRAIN_ERROR, TAP_COUNT, EYE_MONITOR_CLEAR_FLAGS,
               DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD
    );
endinterface

// File: rtl/dqsw_delay_trainer.sv
// Per-lane DQSW training sequencer: sweeps the IOD delay line upward, locks on
// the first EARLY->LATE tap pair, backs off a few taps and reports the position.
module dqsw_delay_trainer #(
    parameter int MAX_TAPS      = 128,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16,
    parameter int BACKOFF_TAPS  = 2
) (
    input  logic                 FAB_CLK,
    input  logic                 RESET,
    dqsw_delay_trainer_if.master bus
);
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_CLEAR   = 4'd2,
        S_SETTLE  = 4'd3,
        S_SAMPLE  = 4'd4,
        S_EVAL    = 4'd5,
        S_MOVE    = 4'd6,
        S_BACKOFF = 4'd7,
        S_DONE    = 4'd8,
        S_ERROR   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        CLS_X = 2'd0,
        CLS_E = 2'd1,
        CLS_L = 2'd2
    } cls_t;

    state_t           state_q;
    cls_t             prev_cls_q;
    cls_t             cls_s;
    logic [CNT_W-1:0] cnt_q;
    logic             early_seen_q;
    logic             late_seen_q;
    logic [3:0]       bo_left_q;
    logic             bo_gap_q;
    logic [7:0]       tap_q;
    logic [7:0]       bo_n_s;
    logic             oor_window_s;
    logic             done_q;
    logic             error_q;
    logic             clear_q;
    logic             move_q;
    logic             dir_q;
    logic             load_q;

    assign bus.TRAIN_DONE              = done_q;
    assign bus.TRAIN_ERROR             = error_q;
    assign bus.TAP_COUNT               = tap_q;
    assign bus.EYE_MONITOR_CLEAR_FLAGS = clear_q;
    assign bus.DELAY_LINE_MOVE         = move_q;
    assign bus.DELAY_LINE_DIRECTION    = dir_q;
    assign bus.DELAY_LINE_LOAD         = load_q;

    // Classify the accumulated eye-monitor flags of the current tap.
    always_comb begin
        cls_s = CLS_X;
        if (early_seen_q && !late_seen_q) begin
            cls_s = CLS_E;
        end else if (late_seen_q && !early_seen_q) begin
            cls_s = CLS_L;
        end else begin
            cls_s = CLS_X;
        end
    end

    // Back-off distance, clamped so the tap position never underflows.
    always_comb begin
        bo_n_s = 8'(BACKOFF_TAPS);
        if (tap_q < 8'(BACKOFF_TAPS)) begin
            bo_n_s = tap_q;
        end else begin
            bo_n_s = 8'(BACKOFF_TAPS);
        end
    end

    // States in which an out-of-range report from the IOD aborts training.
    always_comb begin
        oor_window_s = 1'b0;
        case (state_q)
            S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE,
            S_EVAL, S_MOVE, S_BACKOFF: oor_window_s = 1'b1;
            default:                   oor_window_s = 1'b0;
        endcase
    end

    // Training FSM; every output is set on entry to the state that owns it.
    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            prev_cls_q   <= CLS_X;
            cnt_q        <= '0;
            early_seen_q <= 1'b0;
            late_seen_q  <= 1'b0;
            bo_left_q    <= 4'd0;
            bo_gap_q     <= 1'b0;
            tap_q        <= 8'd0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            clear_q      <= 1'b0;
            move_q       <= 1'b0;
            dir_q        <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            clear_q <= 1'b0;
            move_q  <= 1'b0;
            if (oor_window_s && bus.DELAY_LINE_OUT_OF_RANGE) begin
                state_q <= S_ERROR;
                error_q <= 1'b1;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (bus.TRAIN_START) begin
                            state_q    <= S_LOAD;
                            load_q     <= 1'b1;
                            tap_q      <= 8'd0;
                            prev_cls_q <= CLS_X;
                            done_q     <= 1'b0;
                            error_q    <= 1'b0;
                        end else begin
                            state_q <= state_q;
                        end
                    end
                    S_LOAD, S_MOVE: begin
                        state_q <= S_CLEAR;
                        clear_q <= 1'b1;
                    end
                    S_CLEAR: begin
                        state_q      <= S_SETTLE;
                        early_seen_q <= 1'b0;
                        late_seen_q  <= 1'b0;
                        cnt_q        <= CNT_W'(SETTLE_CYCLES - 1);
                    end
                    S_SETTLE: begin
                        if (cnt_q == '0) begin
                            state_q <= S_SAMPLE;
                            cnt_q   <= CNT_W'(SAMPLE_CYCLES - 1);
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        early_seen_q <= early_seen_q | bus.EYE_MONITOR_EARLY;
                        late_seen_q  <= late_seen_q | bus.EYE_MONITOR_LATE;
                        if (cnt_q == '0) begin
                            state_q <= S_EVAL;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_EVAL: begin
                        prev_cls_q <= cls_s;
                        if ((prev_cls_q == CLS_E) && (cls_s == CLS_L)) begin
                            if (BACKOFF_TAPS == 0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= S_BACKOFF;
                                move_q    <= 1'b1;
                                dir_q     <= 1'b0;
                                tap_q     <= tap_q - 8'd1;
                                bo_left_q <= 4'(bo_n_s - 8'd1);
                                bo_gap_q  <= 1'b0;
                            end
                        end else if (tap_q == 8'(MAX_TAPS - 1)) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= S_MOVE;
                            move_q  <= 1'b1;
                            dir_q   <= 1'b1;
                            tap_q   <= tap_q + 8'd1;
                        end
                    end
                    S_BACKOFF: begin
                        if (!bo_gap_q) begin
                            bo_gap_q <= 1'b1;
                        end else if (bo_left_q == 4'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            move_q    <= 1'b1;
                            dir_q     <= 1'b0;
                            tap_q     <= tap_q - 8'd1;
                            bo_left_q <= bo_left_q - 4'd1;
                            bo_gap_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dqsw_delay_trainer.sv
// Directed bench for dqsw_delay_trainer: an IOD model follows the delay-line
// pulses and returns EARLY/LATE from a per-tap eye profile.
module tb_dqsw_delay_trainer;
    localparam int MAXT       = 32;
    localparam int SETTLE     = 4;
    localparam int SAMPLE     = 8;
    localparam int BACKOFF    = 2;
    localparam int TAP_CYCLES = 1 + SETTLE + SAMPLE + 1 + 1;

    logic clk;
    logic rst;
    dqsw_delay_trainer_if bus ();

    dqsw_delay_trainer #(
        .MAX_TAPS(MAXT), .SETTLE_CYCLES(SETTLE), .SAMPLE_CYCLES(SAMPLE), .BACKOFF_TAPS(BACKOFF)
    ) dut (
        .FAB_CLK(clk),
        .RESET  (rst),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic prof_e [MAXT];
    logic prof_l [MAXT];

    int cyc = 0;
    int iod_tap = 0;
    int n_load = 0, n_clear = 0, n_move = 0, both_high = 0;
    int run_up = 0, run_down = 0, up_gap_bad = 0, down_gap_bad = 0;
    int last_up_cyc = -1, last_down_cyc = -1, done_cyc = -1;
    logic done_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IOD model and pulse monitor, evaluated 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (bus.DELAY_LINE_LOAD) begin
            iod_tap = 0; n_load++; run_up = 0; run_down = 0;
            up_gap_bad = 0; down_gap_bad = 0;
            last_up_cyc = -1; last_down_cyc = -1; done_cyc = -1;
        end
        if (bus.DELAY_LINE_MOVE) begin
            n_move++;
            if (bus.DELAY_LINE_DIRECTION) begin
                iod_tap++; run_up++;
                if (last_up_cyc >= 0 && (cyc - last_up_cyc) != TAP_CYCLES) up_gap_bad++;
                last_up_cyc = cyc;
            end else begin
                iod_tap--; run_down++;
                if (last_down_cyc >= 0 && (cyc - last_down_cyc) != 2) down_gap_bad++;
                last_down_cyc = cyc;
            end
        end
        if (bus.EYE_MONITOR_CLEAR_FLAGS) n_clear++;
        if (bus.TRAIN_DONE && !done_prev) done_cyc = cyc;
        done_prev = bus.TRAIN_DONE;
        if (bus.TRAIN_DONE && bus.TRAIN_ERROR) both_high++;
        if (iod_tap >= 0 && iod_tap < MAXT) begin
            bus.EYE_MONITOR_EARLY = prof_e[iod_tap];
            bus.EYE_MONITOR_LATE  = prof_l[iod_tap];
        end else begin
            bus.EYE_MONITOR_EARLY = 1'b0;
            bus.EYE_MONITOR_LATE  = 1'b0;
        end
    end

    // kind 0: EARLY everywhere; 1: EARLY <10, LATE >=10; 2: EARLY at 0, LATE after;
    // 3: X at 0-3, LATE 4, EARLY 5, LATE from 6.
    task automatic set_profile(input int kind);
        for (int t = 0; t < MAXT; t++) begin
            case (kind)
                0:       begin prof_e[t] = 1'b1;      prof_l[t] = 1'b0;      end
                1:       begin prof_e[t] = (t < 10);  prof_l[t] = (t >= 10); end
                2:       begin prof_e[t] = (t == 0);  prof_l[t] = (t >= 1);  end
                default: begin
                    prof_e[t] = (t <= 3) || (t == 5);
                    prof_l[t] = (t <= 4) || (t >= 6);
                end
            endcase
        end
    endtask

    task automatic start_train();
        @(negedge clk); bus.TRAIN_START = 1'b1;
        @(negedge clk); bus.TRAIN_START = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!(bus.TRAIN_DONE || bus.TRAIN_ERROR) && n < 3000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (!(bus.TRAIN_DONE || bus.TRAIN_ERROR)) begin
            failures++; $display("FAIL %s_end: no DONE/ERROR within %0d cycles", name, n);
        end
    endtask

    task automatic wait_up_move(input int tap, input string name);
        int n;
        n = 0;
        while (!(bus.DELAY_LINE_MOVE && bus.DELAY_LINE_DIRECTION && bus.TAP_COUNT == 8'(tap)) && n < 3000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++; $display("FAIL %s_wait: up-move to tap %0d not seen", name, tap);
        end
    endtask

    task automatic test_reset();
        logic [13:0] outs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        outs = {bus.TRAIN_DONE, bus.TRAIN_ERROR, bus.EYE_MONITOR_CLEAR_FLAGS, bus.DELAY_LINE_MOVE,
                bus.DELAY_LINE_DIRECTION, bus.DELAY_LINE_LOAD, bus.TAP_COUNT};
        checks++; if (outs !== 14'd0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (n_load !== 0 || n_move !== 0) begin failures++; $display("FAIL idle_quiet: loads %0d moves %0d expected 0 0", n_load, n_move); end
    endtask

    task automatic test_lock();
        set_profile(1);
        start_train();
        checks++; if (bus.DELAY_LINE_LOAD !== 1'b1 || bus.TAP_COUNT !== 8'd0) begin failures++; $display("FAIL lock_load: load %0b tap %0d expected 1 0", bus.DELAY_LINE_LOAD, bus.TAP_COUNT); end
        wait_end("lock");
        checks++; if (run_up !== 10) begin failures++; $display("FAIL lock_up_moves: got %0d expected 10", run_up); end
        checks++; if (up_gap_bad !== 0) begin failures++; $display("FAIL lock_up_spacing: %0d gaps differ from %0d", up_gap_bad, TAP_CYCLES); end
        checks++; if (run_down !== 2) begin failures++; $display("FAIL lock_down_moves: got %0d expected 2", run_down); end
        checks++; if (down_gap_bad !== 0) begin failures++; $display("FAIL lock_down_spacing: %0d gaps differ from 2", down_gap_bad); end
        checks++; if (done_cyc - last_down_cyc !== 2) begin failures++; $display("FAIL lock_done_delay: got %0d expected 2", done_cyc - last_down_cyc); end
        repeat (5) @(negedge clk);
        checks++; if (bus.TAP_COUNT !== 8'd8) begin failures++; $display("FAIL lock_tap: got %0d expected 8", bus.TAP_COUNT); end
        checks++; if ({bus.TRAIN_DONE, bus.TRAIN_ERROR, bus.DELAY_LINE_DIRECTION} !== 3'b100) begin failures++; $display("FAIL lock_flags: done/err/dir %b expected 100", {bus.TRAIN_DONE, bus.TRAIN_ERROR, bus.DELAY_LINE_DIRECTION}); end
    endtask

    task automatic test_back_to_back();
        start_train();
        checks++; if ({bus.DELAY_LINE_LOAD, bus.TRAIN_DONE} !== 2'b10 || bus.TAP_COUNT !== 8'd0) begin failures++; $display("FAIL restart_done: load/done %b tap %0d expected 10 0", {bus.DELAY_LINE_LOAD, bus.TRAIN_DONE}, bus.TAP_COUNT); end
        wait_end("b2b");
        checks++; if (bus.TAP_COUNT !== 8'd8 || bus.TRAIN_DONE !== 1'b1) begin failures++; $display("FAIL b2b_result: tap %0d done %0b expected 8 1", bus.TAP_COUNT, bus.TRAIN_DONE); end
    endtask

    task automatic test_all_early();
        set_profile(0);
        start_train();
        wait_end("early");
        repeat (3) @(negedge clk);
        checks++; if (run_up !== MAXT - 1) begin failures++; $display("FAIL early_up_moves: got %0d expected %0d", run_up, MAXT - 1); end
        checks++; if (run_down !== 0) begin failures++; $display("FAIL early_down_moves: got %0d expected 0", run_down); end
        checks++; if (bus.TAP_COUNT !== 8'(MAXT - 1)) begin failures++; $display("FAIL early_tap: got %0d expected %0d", bus.TAP_COUNT, MAXT - 1); end
        checks++; if ({bus.TRAIN_DONE, bus.TRAIN_ERROR, bus.DELAY_LINE_DIRECTION} !== 3'b011) begin failures++; $display("FAIL early_flags: done/err/dir %b expected 011", {bus.TRAIN_DONE, bus.TRAIN_ERROR, bus.DELAY_LINE_DIRECTION}); end
    endtask

    task automatic test_out_of_range();
        int mv, cl;
        set_profile(0);
        start_train();
        checks++; if ({bus.DELAY_LINE_LOAD, bus.TRAIN_ERROR} !== 2'b10) begin failures++; $display("FAIL restart_error: load/err %b expected 10", {bus.DELAY_LINE_LOAD, bus.TRAIN_ERROR}); end
        wait_up_move(5, "oor");
        @(negedge clk);
        @(negedge clk);
        bus.DELAY_LINE_OUT_OF_RANGE = 1'b1;
        @(negedge clk);
        bus.DELAY_LINE_OUT_OF_RANGE = 1'b0;
        checks++; if ({bus.TRAIN_ERROR, bus.TRAIN_DONE} !== 2'b10 || bus.TAP_COUNT !== 8'd5) begin failures++; $display("FAIL oor_error: err/done %b tap %0d expected 10 5", {bus.TRAIN_ERROR, bus.TRAIN_DONE}, bus.TAP_COUNT); end
        mv = n_move; cl = n_clear;
        repeat (30) @(negedge clk);
        checks++; if (n_move !== mv || n_clear !== cl) begin failures++; $display("FAIL oor_quiet: extra moves %0d clears %0d expected 0 0", n_move - mv, n_clear - cl); end
    endtask

    task automatic test_clamp();
        set_profile(2);
        start_train();
        wait_end("clamp");
        repeat (3) @(negedge clk);
        checks++; if (run_up !== 1 || run_down !== 1) begin failures++; $display("FAIL clamp_moves: up %0d down %0d expected 1 1", run_up, run_down); end
        checks++; if (bus.TAP_COUNT !== 8'd0 || bus.TRAIN_DONE !== 1'b1) begin failures++; $display("FAIL clamp_result: tap %0d done %0b expected 0 1", bus.TAP_COUNT, bus.TRAIN_DONE); end
    endtask

    task automatic test_xle_ignore_start();
        int loads;
        set_profile(3);
        start_train();
        loads = n_load;
        wait_up_move(2, "xle");
        start_train();
        wait_end("xle");
        repeat (3) @(negedge clk);
        checks++; if (n_load !== loads) begin failures++; $display("FAIL xle_start_ignored: extra loads %0d expected 0", n_load - loads); end
        checks++; if (run_up !== 6 || run_down !== 2) begin failures++; $display("FAIL xle_moves: up %0d down %0d expected 6 2", run_up, run_down); end
        checks++; if (bus.TAP_COUNT !== 8'd4 || bus.TRAIN_DONE !== 1'b1) begin failures++; $display("FAIL xle_result: tap %0d done %0b expected 4 1", bus.TAP_COUNT, bus.TRAIN_DONE); end
    endtask

    task automatic test_reset_mid();
        logic [13:0] outs;
        int mv;
        set_profile(0);
        start_train();
        wait_up_move(3, "rstmid");
        repeat (1 + SETTLE + 2) @(negedge clk);
        rst = 1'b1;
        #1;
        outs = {bus.TRAIN_DONE, bus.TRAIN_ERROR, bus.EYE_MONITOR_CLEAR_FLAGS, bus.DELAY_LINE_MOVE,
                bus.DELAY_LINE_DIRECTION, bus.DELAY_LINE_LOAD, bus.TAP_COUNT};
        checks++; if (outs !== 14'd0) begin failures++; $display("FAIL rstmid_outputs: got %h expected 0", outs); end
        mv = n_move;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (n_move !== mv) begin failures++; $display("FAIL rstmid_quiet: extra moves %0d expected 0", n_move - mv); end
        start_train();
        checks++; if (bus.DELAY_LINE_LOAD !== 1'b1 || bus.TAP_COUNT !== 8'd0) begin failures++; $display("FAIL rstmid_restart: load %0b tap %0d expected 1 0", bus.DELAY_LINE_LOAD, bus.TAP_COUNT); end
    endtask

    initial begin
        rst = 1'b1;
        bus.TRAIN_START = 1'b0;
        bus.DELAY_LINE_OUT_OF_RANGE = 1'b0;
        bus.EYE_MONITOR_EARLY = 1'b0;
        bus.EYE_MONITOR_LATE = 1'b0;
        set_profile(0);
        test_reset();
        test_lock();
        test_back_to_back();
        test_all_early();
        test_out_of_range();
        test_clamp();
        test_xle_ignore_start();
        test_reset_mid();
        checks++; if (both_high !== 0) begin failures++; $display("FAIL done_error_exclusive: %0d cycles both high expected 0", both_high); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
